// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

  // Default frame timing and width, shared with the transmit side.
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

  // Line level while nothing is being sent.
  localparam logic LINE_IDLE = 1'b1;

  // Frame-tracking states used by both uart_rx_ctrl and uart_tx.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the raw input, then retime it once more to settle metastability.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : uart_sync2

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit validation, mid-bit sampling, holding register
// with valid/ready handshake, and sticky framing-error / overrun flags.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_rx_pin,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  input  logic                 i_err_clr,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS) + 1;

  // Half a bit lands on the middle of the start bit; a full bit from there lands mid-bit.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 w_rx_s;

  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [CNT_W-1:0]     w_clk_cnt_nxt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [IDX_W-1:0]     w_bit_idx_nxt;

  logic                 w_shift_en;
  logic                 w_stop_ok;
  logic                 w_stop_bad;
  logic                 w_overrun_set;

  logic [DATA_BITS-1:0] r_shift;
  logic                 r_deliver;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  // Idle-high synchroniser so reset never looks like a start edge.
  uart_sync2 #(
    .RESET_VAL (LINE_IDLE)
  ) u_rx_sync (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_d      (i_rx_pin),
    .o_q      (w_rx_s)
  );

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
    end
  end

  // Next-state, counter and sample-strobe decode; counters clear on every state change.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_en    = 1'b0;
    w_stop_ok     = 1'b0;
    w_stop_bad    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt   = ST_START;
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
        end
      end

      ST_START: begin
        if (r_clk_cnt == CNT_HALF) begin
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = w_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end

      ST_DATA: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_shift_en    = 1'b1;
          w_clk_cnt_nxt = '0;
          if (r_bit_idx == IDX_LAST) begin
            w_state_nxt   = ST_STOP;
            w_bit_idx_nxt = '0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (r_clk_cnt == CNT_LAST) begin
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          if (w_rx_s) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end

      ST_BREAK: begin
        if (w_rx_s) begin
          w_state_nxt   = ST_IDLE;
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_clk_cnt_nxt = '0;
        w_bit_idx_nxt = '0;
      end
    endcase
  end

  // LSB-first shift: each sample enters at the top, so after DATA_BITS samples bit 0 is at the bottom.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
    end
  end

  // Delivery strobe, one cycle after a good stop bit.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_deliver <= 1'b0;
    end else begin
      r_deliver <= w_stop_ok;
    end
  end

  // Holding register: accept a new byte if empty or being drained this cycle, otherwise drop it.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (r_deliver) begin
      if (!r_rx_valid || i_rx_ready) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end
    end else if (r_rx_valid && i_rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign w_overrun_set = r_deliver && r_rx_valid && !i_rx_ready;

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_stop_bad) begin
        r_frame_err <= 1'b1;
      end else if (i_err_clr) begin
        r_frame_err <= 1'b0;
      end

      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (i_err_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != ST_IDLE);

endmodule : uart_rx_ctrl

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the host's UART debug/command link. Synchronises the raw RX pin, detects and validates the start bit, and times mid-bit sampling from a per-bit clock divider. It shifts in LSB-first data and checks the stop bit. Completed bytes go to a single holding register with a valid/ready handshake, and sticky framing-error and overrun status flags are kept for the host register block.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; even, >= 4
DATA_BITS, 8, data bits per frame; 5..8

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous, active-low reset
rx_pin  input  1  raw asynchronous serial line, idle high
rx_data  output  DATA_BITS  received byte, stable while rx_valid=1
rx_valid  output  1  holding register contains an unread byte
rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte completed while holding register full
err_clr  input  1  one-cycle pulse clears frame_err and overrun
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (resetn=0, async): state=IDLE, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0. Synchroniser flops reset to 1. Bit counter and clock counter reset to 0.
- Input sync: 2-flop synchroniser rx_pin -> rx_s. All decisions use rx_s only.
- Counters:
  - clk_cnt has width clog2(CLKS_PER_BIT).
  - bit_idx has width clog2(DATA_BITS)+1.
  - Neither counter wraps past its terminal value; each is reset on every state change.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s==0 -> START, clk_cnt=0.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit).
    - rx_s==0 there -> DATA, clk_cnt=0, bit_idx=0.
    - rx_s==1 there -> IDLE. False start; no flags, no output change.
  - DATA: at clk_cnt==CLKS_PER_BIT-1, shift[bit_idx]<=rx_s, bit_idx++, clk_cnt=0.
    - After the sample where bit_idx==DATA_BITS-1 -> STOP.
  - STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s.
    - 1 -> deliver shift, go to IDLE.
    - 0 -> frame_err<=1, byte discarded, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. Prevents a break or low line from being read as repeated starts.
- Delivery, in the cycle after the stop sample:
  - If rx_valid==0, or rx_valid&&rx_ready in the delivering cycle: rx_data<=shift, rx_valid<=1.
  - Otherwise: overrun<=1. The new byte is dropped; rx_data and rx_valid are unchanged.
- Handshake: rx_valid&&rx_ready with no simultaneous delivery -> rx_valid<=0. rx_data retains its value (not cleared). rx_ready while rx_valid==0 has no effect.
- Sticky flags:
  - err_clr clears both frame_err and overrun.
  - A set event in the same cycle as err_clr wins; the flag stays 1.
- Latency:
  - Start edge on rx_pin to leaving IDLE: 3 clk (2 sync + state register).
  - rx_valid rises 1 clk after the stop-bit sample.
  - Total from pin falling edge ≈ 3 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 clk.
- Back-to-back frames: returning to IDLE right after the stop-bit sample allows a new start edge half a bit later. No dead time is required.
- Reset mid-frame: all state is abandoned immediately. After release the FSM starts in IDLE, and a still-low line is treated as a start edge.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, START, DATA, STOP, BREAK), default CLKS_PER_BIT, DATA_BITS. The uart_tx side reuses these.
- One natural sub-module: uart_sync2 (2-flop synchroniser with reset value parameter), also reused by uart_tx for CTS. Counters and FSM stay in this module.

Test Plan:
All with CLKS_PER_BIT=16, DATA_BITS=8.
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), rx_ready=1 -> rx_data=0xA5, rx_valid high exactly 1 cycle, frame_err=0, overrun=0, busy low after stop sample.
- rx_pin low for 4 clk then high -> no rx_valid, FSM returns to IDLE from START, no flags.
- Frame 0x3C with stop bit 0, line held low 40 clk then high -> frame_err=1, rx_valid stays 0, busy stays high until line is high, then next frame 0x01 is received correctly.
- Two frames 0x11 then 0x22, rx_ready=0 throughout -> rx_data=0x11, rx_valid=1, overrun=1. Then rx_ready=1 for one cycle -> rx_valid=0. Then err_clr -> overrun=0.
- err_clr pulsed in the same cycle as an overrun event -> overrun remains 1.
- resetn asserted at bit 4 of frame 0xFF, released with line high -> all outputs at reset values. A following frame 0x5A gives rx_data=0x5A with no flags.
